// File: rtl/data_memory.sv
// data_memory: byte-addressable big-endian doubleword data memory; define DMEM_MISALIGN_CHECK_EN to add the misaligned flag
module data_memory #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] read_data
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic                  misaligned
`endif
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BYTES_A = ADDR_WIDTH'(BYTES);
  logic [7:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] raw;
  logic bad;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign bad = reset & (MemRead | MemWrite) & ((address % BYTES_A) != '0);
  assign misaligned = bad;
`else
  assign bad = 1'b0;
`endif
  // store bytes MSB-first from address upward, wrapping at the top; reset clears everything
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (MemWrite && !bad)
      for (int i = 0; i < BYTES; i++) mem[address + ADDR_WIDTH'(i)] <= write_data[DATA_WIDTH-1-8*i -: 8];
  // gather the doubleword combinationally, MSB from the lowest (wrapped) address
  always_comb begin
    raw = '0;
    for (int i = 0; i < BYTES; i++) raw[DATA_WIDTH-1-8*i -: 8] = mem[address + ADDR_WIDTH'(i)];
  end
  assign read_data = (MemRead && reset && !bad) ? raw : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized self-checking bench for data_memory against a byte-array model
module tb_data_memory;
  logic clk = 0, reset = 0, MemRead = 0, MemWrite = 0;
  logic [9:0] address = '0;
  logic [63:0] write_data = '0, read_data;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic misaligned;
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  int n_tests = 0, n_fail = 0;
  logic [7:0] model [1024];
  logic [9:0] a;
  logic [63:0] d;
  bit r, w;

  data_memory dut (
    .clk(clk), .reset(reset), .address(address), .write_data(write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .read_data(read_data)
`ifdef DMEM_MISALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit mis_at(input logic [9:0] x);
    return MIS && (x % 8 != 0);
  endfunction

  function automatic logic [63:0] model_read(input logic [9:0] x);
    logic [63:0] v = '0;
    if (mis_at(x)) return '0;
    for (int i = 0; i < 8; i++) v = {v[55:0], model[(int'(x) + i) % 1024]};
    return v;
  endfunction

  task automatic model_write(input logic [9:0] x, input logic [63:0] v);
    if (!mis_at(x))
      for (int i = 0; i < 8; i++) model[(int'(x) + i) % 1024] = v[63-8*i -: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model[i] = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [9:0] x, input logic [63:0] v);
    @(negedge clk);
    address = x; write_data = v; MemWrite = 1; MemRead = 0;
    @(posedge clk);
    model_write(x, v);
    #1 MemWrite = 0;
  endtask

  task automatic rd(input string tag, input logic [9:0] x, input logic [63:0] exp);
    @(negedge clk);
    address = x; MemRead = 1; MemWrite = 0;
    #1 check(tag, read_data, exp);
  endtask

  initial begin
    model_clear();
    MemRead = 1;
    #3 check("rst_hold", read_data, 64'h0);
    #7 reset = 1;
    rd("rst_a0", 10'd0, 64'h0);
    rd("rst_a8", 10'd8, 64'h0);
    rd("rst_a1016", 10'd1016, 64'h0);
    wr(10'd0, 64'h1122334455667788);
    rd("rd_a0", 10'd0, 64'h1122334455667788);
    check("dump0", 64'(dut.mem[0]), 64'h11);
    check("dump7", 64'(dut.mem[7]), 64'h88);
    wr(10'd8, 64'hDEADBEEFCAFEF00D);
    rd("rd_a4", 10'd4, MIS ? 64'h0 : 64'h55667788DEADBEEF);
    @(negedge clk); MemRead = 0;
    #1 check("rd_off", read_data, 64'h0);
    wr(10'd1020, 64'hA1A2A3A4A5A6A7A8);
    rd("wrap", 10'd1020, MIS ? 64'h0 : 64'hA1A2A3A4A5A6A7A8);
    check("dump1020", 64'(dut.mem[1020]), MIS ? 64'h0 : 64'hA1);
    check("dump3", 64'(dut.mem[3]), MIS ? 64'h44 : 64'hA8);
    @(negedge clk);
    address = 10'd16; write_data = 64'h0102030405060708; MemRead = 1; MemWrite = 1;
    #1 check("rw_before", read_data, 64'h0);
    @(posedge clk);
    model_write(10'd16, 64'h0102030405060708);
    #1 check("rw_after", read_data, 64'h0102030405060708);
    MemWrite = 0;
`ifdef DMEM_MISALIGN_CHECK_EN
    @(negedge clk);
    address = 10'd3; write_data = '1; MemWrite = 1; MemRead = 0;
    #1 check("mis_flag", 64'(misaligned), 64'h1);
    @(posedge clk);
    #1 MemWrite = 0;
    check("mis_unchanged", 64'(dut.mem[3]), 64'h44);
    rd("mis_aligned_flag", 10'd8, 64'hDEADBEEFCAFEF00D);
    check("mis_flag_aligned", 64'(misaligned), 64'h0);
`endif
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      a = 10'($urandom_range(0, 47)) + (($urandom_range(0, 1) == 1) ? 10'd1000 : 10'd0);
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
      d = {$urandom, $urandom};
      r = $urandom_range(0, 1) == 1;
      w = $urandom_range(0, 2) == 0;
      address = a; write_data = d; MemRead = r; MemWrite = w;
      #1 check(r ? "rand_pre" : "rand_off", read_data, r ? model_read(a) : 64'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
      check("rand_mis", 64'(misaligned), 64'((r || w) && a[2:0] != 3'd0));
`endif
      @(posedge clk);
      if (w) model_write(a, d);
      #1 if (r) check("rand_post", read_data, model_read(a));
    end
    wr(10'd16, 64'h0102030405060708);
    @(posedge clk);
    #2 reset = 0;
    MemRead = 1; MemWrite = 0; address = 10'd16;
    #1 check("rst_mid_a16", read_data, 64'h0);
    address = 10'd0; #1 check("rst_mid_a0", read_data, 64'h0);
    address = 10'd1020; #1 check("rst_mid_a1020", read_data, 64'h0);
    check("rst_mid_dump16", 64'(dut.mem[16]), 64'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
    address = 10'd3; #1 check("rst_mis", 64'(misaligned), 64'h0);
`endif
    address = 10'd0; write_data = '1; MemWrite = 1;
    @(posedge clk);
    #1 check("rst_write_dropped", 64'(dut.mem[0]), 64'h0);
    @(negedge clk);
    reset = 1; MemWrite = 0;
    model_clear();
    #1 check("post_rst_a0", read_data, 64'h0);
    wr(10'd24, 64'h0F1E2D3C4B5A6978);
    rd("post_rst_wr", 10'd24, 64'h0F1E2D3C4B5A6978);
    rd("post_rst_a20", 10'd20, model_read(10'd20));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressable data memory for the RISC datapath's MEM stage.
- Stores 2**ADDR_WIDTH bytes.
- Reads and writes one DATA_WIDTH-bit doubleword per access, in big-endian byte order: the most significant byte is at the lowest address.
- Writes are synchronous. Reads are combinational.

Parameters:
- ADDR_WIDTH, 10, byte-address width; memory depth = 2**ADDR_WIDTH bytes (1024).
- DATA_WIDTH, 64, access width in bits; must be a multiple of 8; BYTES = DATA_WIDTH/8 (8).

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-low reset; clears the entire memory while low.
- address  input  ADDR_WIDTH  byte address of the first (most significant) byte of the access.
- write_data  input  DATA_WIDTH  doubleword to store.
- MemRead  input  1  read enable.
- MemWrite  input  1  write enable.
- read_data  output  DATA_WIDTH  doubleword read.

Behaviour:
- Storage: internal byte array named mem, indices 0..2**ADDR_WIDTH-1, 8 bits each. The name is fixed so benches can dump it hierarchically (hex dump).
- Reset: when reset goes low, every mem byte becomes 0x00 immediately, with no clock needed. While reset is low, writes are ignored and read_data = 0.
- Write, on the rising clk edge with reset high and MemWrite=1:
  - mem[address+i] <= write_data[DATA_WIDTH-1-8*i -: 8] for i = 0..BYTES-1.
  - Example: 0x1122334455667788 at address 0 gives mem[0]=0x11 … mem[7]=0x88.
- Read: purely combinational, zero latency.
  - When MemRead=1 and reset is high: read_data = {mem[address], mem[address+1], …, mem[address+BYTES-1]}.
  - When MemRead=0: read_data = 0.
- Address arithmetic: byte offsets are computed modulo 2**ADDR_WIDTH.
  - An access at 1020 touches bytes 1020..1023, then 0..3.
  - No error is raised. Unaligned addresses are legal.
- Simultaneous MemRead and MemWrite at the same address:
  - Before the clock edge, read_data shows the old contents.
  - After the edge, it shows the new data.
  - There is no write-through bypass within the cycle.
- When reset deasserts asynchronously, the memory is zero and the first write can occur at the next rising edge.
- If reset asserts during a write cycle, reset wins: the memory is zero and the write is dropped.
- No X is ever propagated from an initialized memory. Reset is required before use.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Adds output port misaligned, 1 bit, combinational.
  - misaligned = (MemRead | MemWrite) & (address mod BYTES != 0).
  - A misaligned write is suppressed, leaving the memory unchanged.
  - A misaligned read returns 0.
  - misaligned = 0 during reset.
- Undefined: the port is absent and unaligned accesses behave as in Behaviour (wrap-around, no error).

Test Plan:
- Reset low for 10 ns, then high; read addresses 0, 8, 1016 with MemRead=1 -> read_data = 0x0000000000000000 each.
- Write 0x1122334455667788 to address 0 (one cycle with MemWrite=1); then MemRead=1 at address 0 -> read_data = 0x1122334455667788; hex dump shows mem[0]=11, mem[7]=88.
- Write 0xDEADBEEFCAFEF00D to address 8, then read address 4 -> 0x55667788DEADBEEF; MemRead=0 -> read_data = 0.
- Write 0xA1A2A3A4A5A6A7A8 to address 1020 -> mem[1020..1023]=A1..A4 and mem[0..3]=A5..A8; read address 1020 returns the same value.
- Same-cycle MemRead+MemWrite at address 16 with old value 0 and write 0x0102030405060708 -> read_data = 0 before the edge and 0x0102030405060708 after it.
- Pull reset low mid-cycle after the writes above -> all reads return 0 immediately. With DMEM_MISALIGN_CHECK_EN, writing at address 3 -> misaligned=1 and the memory is unchanged.
